// File: rtl/jtkicker_obj_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// jtkicker_obj_pkg : object entry layout and scanner state encoding
// Revision: 1.0
// ------------------------------------------------------------------
package jtkicker_obj_pkg;

    localparam logic [1:0] c_byte_attr = 2'd0;
    localparam logic [1:0] c_byte_code = 2'd1;
    localparam logic [1:0] c_byte_x    = 2'd2;
    localparam logic [1:0] c_byte_y    = 2'd3;

    localparam int c_attr_code8 = 4;
    localparam int c_attr_hflip = 6;
    localparam int c_attr_vflip = 7;

    localparam logic [7:0] c_obj_height = 8'd16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CHECK = 3'd2,
        S_REQ   = 3'd3,
        S_WAIT  = 3'd4,
        S_NEXT  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/jtkicker_objscan.sv
`default_nettype none
// ------------------------------------------------------------------
// jtkicker_objscan : walks the object table once per line and issues
//                    draw requests for objects covering that line
// Revision: 1.0
// ------------------------------------------------------------------
module jtkicker_objscan
    import jtkicker_obj_pkg::*;
#(
    parameter int         OBJ_AW  = 6,
    parameter logic [7:0] YOFFSET = 8'd0,
    parameter bit         REVERSE = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen2,
    input  logic              hinit_x,
    input  logic [7:0]        vrender,
    output logic [OBJ_AW+1:0] obj_addr,
    input  logic [7:0]        obj_dout,
    output logic              draw,
    input  logic              busy,
    output logic [7:0]        xpos,
    output logic [3:0]        ysub,
    output logic [3:0]        pal,
    output logic              hflip,
    output logic              vflip,
    output logic [8:0]        code,
    output logic              done
);

    localparam logic [OBJ_AW-1:0] c_first = REVERSE ? {OBJ_AW{1'b1}} : {OBJ_AW{1'b0}};
    localparam logic [OBJ_AW-1:0] c_last  = REVERSE ? {OBJ_AW{1'b0}} : {OBJ_AW{1'b1}};

    state_t              state_q;
    logic [OBJ_AW-1:0]   entry_q;
    logic [OBJ_AW-1:0]   entry_d;
    logic [2:0]          rd_cnt_q;
    logic [7:0]          bytes_q [4];
    logic [OBJ_AW+1:0]   obj_addr_q;
    logic                draw_q;
    logic                done_q;
    logic [7:0]          xpos_q;
    logic [3:0]          ysub_q;
    logic [3:0]          pal_q;
    logic                hflip_q;
    logic                vflip_q;
    logic [8:0]          code_q;
    logic [7:0]          w_ydiff;
    logic                w_hit;
    logic                w_unused_attr5;

    // Modulo-256 difference lets objects straddling line 255/0 match
    assign w_ydiff        = vrender + YOFFSET - bytes_q[c_byte_y];
    assign w_hit          = w_ydiff < c_obj_height;
    assign entry_d        = REVERSE ? entry_q - 1'b1 : entry_q + 1'b1;
    assign w_unused_attr5 = bytes_q[c_byte_attr][5];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            entry_q    <= c_first;
            rd_cnt_q   <= 3'd0;
            obj_addr_q <= '0;
            draw_q     <= 1'b0;
            done_q     <= 1'b0;
            xpos_q     <= 8'd0;
            ysub_q     <= 4'd0;
            pal_q      <= 4'd0;
            hflip_q    <= 1'b0;
            vflip_q    <= 1'b0;
            code_q     <= 9'd0;
            for (int i = 0; i < 4; i++) bytes_q[i] <= 8'd0;
        end else if (cen2) begin
            if (hinit_x) begin
                state_q    <= S_READ;
                entry_q    <= c_first;
                rd_cnt_q   <= 3'd0;
                obj_addr_q <= {c_first, 2'd0};
                draw_q     <= 1'b0;
                done_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: ;
                    S_READ: begin
                        // Address goes out on pulses 0..3, data lands one pulse later
                        if (rd_cnt_q < 3'd4)
                            obj_addr_q <= {entry_q, rd_cnt_q[1:0]};
                        if (rd_cnt_q != 3'd0)
                            bytes_q[rd_cnt_q[1:0] - 2'd1] <= obj_dout;
                        if (rd_cnt_q == 3'd4)
                            state_q <= S_CHECK;
                        else
                            rd_cnt_q <= rd_cnt_q + 3'd1;
                    end
                    S_CHECK: begin
                        if (!w_hit) begin
                            state_q <= S_NEXT;
                        end else if (!busy) begin
                            xpos_q  <= bytes_q[c_byte_x];
                            ysub_q  <= w_ydiff[3:0];
                            pal_q   <= bytes_q[c_byte_attr][3:0];
                            hflip_q <= bytes_q[c_byte_attr][c_attr_hflip];
                            vflip_q <= bytes_q[c_byte_attr][c_attr_vflip];
                            code_q  <= {bytes_q[c_byte_attr][c_attr_code8], bytes_q[c_byte_code]};
                            draw_q  <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (busy) begin
                            draw_q  <= 1'b0;
                            state_q <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (!busy) state_q <= S_NEXT;
                    end
                    S_NEXT: begin
                        if (entry_q == c_last) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            entry_q    <= entry_d;
                            rd_cnt_q   <= 3'd0;
                            obj_addr_q <= {entry_d, 2'd0};
                            state_q    <= S_READ;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign obj_addr = obj_addr_q;
    assign draw     = draw_q;
    assign done     = done_q;
    assign xpos     = xpos_q;
    assign ysub     = ysub_q;
    assign pal      = pal_q;
    assign hflip    = hflip_q;
    assign vflip    = vflip_q;
    assign code     = code_q;

endmodule
`default_nettype wire

// File: tb/tb_jtkicker_objscan.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_jtkicker_objscan : directed bench for the object scanner
// Revision: 1.0
// ------------------------------------------------------------------
module tb_jtkicker_objscan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen2 = 1'b0;
    logic       hinit_x = 1'b0;
    logic       hinit_r = 1'b0;
    logic       busy = 1'b0;
    logic       busy_r = 1'b0;
    logic [7:0] vrender = 8'd0;
    logic [7:0] mem [256];

    logic [7:0] obj_addr, obj_addr_r, obj_dout, obj_dout_r;
    logic       draw, done, hflip, vflip, draw_r, done_r, hflip_r, vflip_r;
    logic [7:0] xpos, xpos_r;
    logic [3:0] ysub, pal, ysub_r, pal_r;
    logic [8:0] code, code_r;
    logic [26:0] w_f;

    assign obj_dout   = mem[obj_addr];
    assign obj_dout_r = mem[obj_addr_r];
    assign w_f        = {xpos, ysub, pal, hflip, vflip, code};

    jtkicker_objscan u_fwd (
        .clk(clk), .rst_n(rst_n), .cen2(cen2), .hinit_x(hinit_x), .vrender(vrender),
        .obj_addr(obj_addr), .obj_dout(obj_dout), .draw(draw), .busy(busy),
        .xpos(xpos), .ysub(ysub), .pal(pal), .hflip(hflip), .vflip(vflip),
        .code(code), .done(done)
    );

    jtkicker_objscan #(.REVERSE(1'b1)) u_rev (
        .clk(clk), .rst_n(rst_n), .cen2(cen2), .hinit_x(hinit_r), .vrender(vrender),
        .obj_addr(obj_addr_r), .obj_dout(obj_dout_r), .draw(draw_r), .busy(busy_r),
        .xpos(xpos_r), .ysub(ysub_r), .pal(pal_r), .hflip(hflip_r), .vflip(vflip_r),
        .code(code_r), .done(done_r)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ph = 0;
    int pend = 0, bcnt = 0, bdelay = 1, blen = 2, bcnt_r = 0;
    int exp_len = 0, draw_len = 0;
    bit addr_chk = 1'b1;
    logic p_draw = 1'b0;
    logic [7:0] p_addr = 8'd0;
    logic [26:0] rec = '0;
    int ents[$];
    logic [26:0] flds[$];
    int ents_r[$];

    function automatic logic [26:0] fld(input logic [7:0] x, input logic [3:0] ys,
                                        input logic [3:0] pl, input logic hf,
                                        input logic vf, input logic [8:0] cd);
        return {x, ys, pl, hf, vf, cd};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // cen2 generator, busy responders and handshake monitor; one step per cen2 pulse
    initial begin : monitor
        logic b_seen;
        forever begin
            @(negedge clk);
            if (cen2 && rst_n) begin
                b_seen = busy;
                if (draw && !p_draw) begin
                    checks++;
                    if (b_seen) begin
                        failures++;
                        $display("FAIL draw_rise_busy: got busy=%0b want 0", b_seen);
                    end
                    rec = w_f;
                    ents.push_back(int'(obj_addr[7:2]));
                    flds.push_back(w_f);
                    draw_len = 1;
                end else if (draw && p_draw) begin
                    draw_len++;
                    checks++;
                    if (w_f !== rec) begin
                        failures++;
                        $display("FAIL field_hold: got %0h want %0h", w_f, rec);
                    end
                end else if (!draw && p_draw) begin
                    checks++;
                    if (!b_seen) begin
                        failures++;
                        $display("FAIL draw_drop: got busy=%0b want 1", b_seen);
                    end
                    if (exp_len != 0) begin
                        checks++;
                        if (draw_len != exp_len) begin
                            failures++;
                            $display("FAIL draw_len: got %0d want %0d", draw_len, exp_len);
                        end
                    end
                end
                if (addr_chk && b_seen && !draw) begin
                    checks++;
                    if (obj_addr !== p_addr) begin
                        failures++;
                        $display("FAIL addr_busy: got %0h want %0h", obj_addr, p_addr);
                    end
                end
                if (bcnt > 0) begin
                    bcnt--;
                    if (bcnt == 0) busy = 1'b0;
                end else if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        busy = 1'b1;
                        bcnt = blen;
                    end
                end else if (draw && !busy) begin
                    pend = bdelay;
                end
                if (draw_r && !busy_r && bcnt_r == 0) ents_r.push_back(int'(obj_addr_r[7:2]));
                if (bcnt_r > 0) begin
                    bcnt_r--;
                    if (bcnt_r == 0) busy_r = 1'b0;
                end else if (draw_r && !busy_r) begin
                    busy_r = 1'b1;
                    bcnt_r = 2;
                end
                p_draw = draw;
                p_addr = obj_addr;
            end
            ph = (ph == 2) ? 0 : ph + 1;
            cen2 = (ph == 0);
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            mem[4*i]   = 8'h00;
            mem[4*i+1] = 8'h00;
            mem[4*i+2] = 8'h00;
            mem[4*i+3] = 8'hF0;
        end
        for (int i = 256; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic set_ent(input int e, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
        mem[4*e] = b0; mem[4*e+1] = b1; mem[4*e+2] = b2; mem[4*e+3] = b3;
    endtask

    // Held for three clocks so exactly one cen2 pulse sees it
    task automatic pulse_hinit(input bit rev);
        @(negedge clk);
        if (rev) hinit_r = 1'b1; else hinit_x = 1'b1;
        repeat (3) @(negedge clk);
        hinit_x = 1'b0;
        hinit_r = 1'b0;
    endtask

    task automatic wait_done(input bit rev, input string nm);
        int n;
        n = 0;
        while (((rev ? done_r : done) !== 1'b1) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 30000) begin
            failures++;
            $display("FAIL %s_timeout: got done=0 want 1", nm);
        end
    endtask

    typedef struct {
        logic [7:0]  b0, b1, b2, b3, vr;
        int          ndraw;
        logic [26:0] exp;
    } vec_t;

    vec_t vt[6];

    initial begin : main
        int n;
        vt[0] = '{8'h25, 8'h3C, 8'h80, 8'h70, 8'h75, 1, fld(8'h80, 4'h5, 4'h5, 1'b0, 1'b0, 9'h03C)};
        vt[1] = '{8'hD0, 8'hFF, 8'h40, 8'h70, 8'h70, 1, fld(8'h40, 4'h0, 4'h0, 1'b1, 1'b1, 9'h1FF)};
        vt[2] = '{8'h0A, 8'h12, 8'h33, 8'hF8, 8'h03, 1, fld(8'h33, 4'hB, 4'hA, 1'b0, 1'b0, 9'h012)};
        vt[3] = '{8'h05, 8'h11, 8'h22, 8'h10, 8'h05, 0, '0};
        vt[4] = '{8'h4F, 8'hAA, 8'hFF, 8'h50, 8'h5F, 1, fld(8'hFF, 4'hF, 4'hF, 1'b1, 1'b0, 9'h0AA)};
        vt[5] = '{8'h03, 8'h01, 8'h10, 8'h50, 8'h60, 0, '0};

        clear_mem();
        repeat (8) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_fwd", {27'(w_f), draw, done, obj_addr}, 64'd0);
        chk("reset_rev", {xpos_r, ysub_r, pal_r, hflip_r, vflip_r, code_r, draw_r, done_r, obj_addr_r}, 64'd0);

        bdelay = 1; blen = 2; exp_len = 2;
        for (int i = 0; i < 6; i++) begin
            clear_mem();
            set_ent(0, vt[i].b0, vt[i].b1, vt[i].b2, vt[i].b3);
            vrender = vt[i].vr;
            ents.delete(); flds.delete();
            pulse_hinit(1'b0);
            chk($sformatf("vec%0d_done_clr", i), 64'(done), 64'd0);
            wait_done(1'b0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_ndraw", i), 64'(ents.size()), 64'(vt[i].ndraw));
            if (vt[i].ndraw == 1 && ents.size() == 1) begin
                chk($sformatf("vec%0d_fields", i), 64'(flds[0]), 64'(vt[i].exp));
                chk($sformatf("vec%0d_entry", i), 64'(ents[0]), 64'd0);
            end
        end

        // Slow drawer: accepts three pulses late and stays busy for twenty
        clear_mem();
        set_ent(5, 8'h01, 8'h05, 8'h11, 8'h40);
        set_ent(6, 8'h02, 8'h06, 8'h22, 8'h45);
        vrender = 8'h48;
        bdelay = 3; blen = 20; exp_len = 4;
        ents.delete(); flds.delete();
        pulse_hinit(1'b0);
        wait_done(1'b0, "hs");
        chk("hs_ndraw", 64'(ents.size()), 64'd2);
        if (ents.size() == 2) begin
            chk("hs_order", {32'(ents[0]), 32'(ents[1])}, {32'd5, 32'd6});
            chk("hs_f0", 64'(flds[0]), 64'(fld(8'h11, 4'h8, 4'h1, 1'b0, 1'b0, 9'h005)));
            chk("hs_f1", 64'(flds[1]), 64'(fld(8'h22, 4'h3, 4'h2, 1'b0, 1'b0, 9'h006)));
        end

        // Restart while waiting on the drawer for entry 10
        clear_mem();
        set_ent(10, 8'h03, 8'h0A, 8'h30, 8'h20);
        vrender = 8'h22;
        bdelay = 1; blen = 20; exp_len = 2;
        ents.delete(); flds.delete();
        pulse_hinit(1'b0);
        n = 0;
        while (!(ents.size() == 1 && !draw && busy) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        chk("rs_reach_wait", 64'(n < 30000), 64'd1);
        addr_chk = 1'b0;
        pulse_hinit(1'b0);
        chk("rs_state", {draw, done, obj_addr}, 64'd0);
        wait_done(1'b0, "rs");
        addr_chk = 1'b1;
        chk("rs_ndraw", 64'(ents.size()), 64'd2);
        if (ents.size() == 2) begin
            chk("rs_entry", 64'(ents[1]), 64'd10);
            chk("rs_f", 64'(flds[1]), 64'(fld(8'h30, 4'h2, 4'h3, 1'b0, 1'b0, 9'h00A)));
        end

        // Descending scan
        clear_mem();
        set_ent(2, 8'h07, 8'h02, 8'h12, 8'h30);
        set_ent(60, 8'h08, 8'h3C, 8'h34, 8'h31);
        vrender = 8'h33;
        ents_r.delete();
        pulse_hinit(1'b1);
        wait_done(1'b1, "rev");
        chk("rev_ndraw", 64'(ents_r.size()), 64'd2);
        if (ents_r.size() == 2)
            chk("rev_order", {32'(ents_r[0]), 32'(ents_r[1])}, {32'd60, 32'd2});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
